// File: rtl/param_adder.sv
`default_nettype none
// ============================================================================
//  Module      : param_adder
//  Description : Width-configurable unsigned adder with one-cycle registered
//                result, carry-out flag and optional clamp-to-all-ones
//                saturation on overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module param_adder #(
    parameter int unsigned SIZE     = 4,
    parameter int unsigned SATURATE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] sum,
    output logic            carry,
    output logic            out_valid
);

    localparam logic [SIZE-1:0] c_all_ones = '1;

    // Full-width sum: bit SIZE is the carry-out of the unsigned addition.
    logic [SIZE:0]   w_full;
    // Value that lands in the sum register for a valid operand pair.
    logic [SIZE-1:0] w_result;

    logic [SIZE-1:0] sum_d;
    logic [SIZE-1:0] sum_q;
    logic            carry_d;
    logic            carry_q;
    logic            out_valid_d;
    logic            out_valid_q;

    // Zero-extend both operands so the carry falls out as the top bit.
    assign w_full = {1'b0, a} + {1'b0, b};

    // Select between wrapping and clamping behaviour at elaboration time.
    generate
        if (SATURATE != 0) begin : g_sat
            assign w_result = w_full[SIZE] ? c_all_ones : w_full[SIZE-1:0];
        end else begin : g_wrap
            assign w_result = w_full[SIZE-1:0];
        end
    endgenerate

    // Next-state: load on valid input, otherwise hold the result and drop valid.
    // Operands are only looked at under in_valid, so X operands on idle
    // cycles never reach the registers.
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = w_result;
            carry_d     = w_full[SIZE];
            out_valid_d = 1'b1;
        end
    end

    // Result registers, cleared immediately by reset without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_param_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_adder
//  Description : Self-checking bench for param_adder across several widths
//                and both saturation modes, against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_adder;

    localparam int NDUT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;

    int checks = 0;
    int errors = 0;

    // Instance set: {SIZE,SATURATE} = {2,0},{2,1},{8,0},{8,1},{1,0}
    logic [1:0] s2, s2s;
    logic [7:0] s8, s8s;
    logic [0:0] s1;
    logic       c2, c2s, c8, c8s, c1;
    logic       v2, v2s, v8, v8s, v1;

    param_adder #(.SIZE(2), .SATURATE(0)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[1:0]), .b(b[1:0]),
        .sum(s2), .carry(c2), .out_valid(v2));
    param_adder #(.SIZE(2), .SATURATE(1)) u_d2s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[1:0]), .b(b[1:0]),
        .sum(s2s), .carry(c2s), .out_valid(v2s));
    param_adder #(.SIZE(8), .SATURATE(0)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .sum(s8), .carry(c8), .out_valid(v8));
    param_adder #(.SIZE(8), .SATURATE(1)) u_d8s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .sum(s8s), .carry(c8s), .out_valid(v8s));
    param_adder #(.SIZE(1), .SATURATE(0)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
        .sum(s1), .carry(c1), .out_valid(v1));

    always #5 clk = ~clk;

    int sizes [NDUT] = '{2, 2, 8, 8, 1};
    bit sats  [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    logic [7:0] act_sum   [NDUT];
    logic       act_carry [NDUT];
    logic       act_valid [NDUT];

    always_comb begin
        act_sum[0] = {6'd0, s2};  act_carry[0] = c2;  act_valid[0] = v2;
        act_sum[1] = {6'd0, s2s}; act_carry[1] = c2s; act_valid[1] = v2s;
        act_sum[2] = s8;          act_carry[2] = c8;  act_valid[2] = v8;
        act_sum[3] = s8s;         act_carry[3] = c8s; act_valid[3] = v8s;
        act_sum[4] = {7'd0, s1};  act_carry[4] = c1;  act_valid[4] = v1;
    end

    // Arithmetic reference: {carry, sum} for a SIZE-bit add.
    function automatic logic [8:0] ref_add(int size, bit sat, logic [7:0] x, logic [7:0] y);
        int unsigned maxv = (1 << size) - 1;
        int unsigned xv   = int'(x) & maxv;
        int unsigned yv   = int'(y) & maxv;
        int unsigned tot  = xv + yv;
        bit          cy   = (tot > maxv);
        int unsigned res  = (sat && cy) ? maxv : (tot & maxv);
        return {cy, res[7:0]};
    endfunction

    // Model state: what each instance must be showing after the latest edge.
    logic [7:0] m_sum   [NDUT] = '{default: 8'd0};
    logic       m_carry [NDUT] = '{default: 1'b0};
    logic       m_valid [NDUT] = '{default: 1'b0};

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                m_sum[k]   <= 8'd0;
                m_carry[k] <= 1'b0;
                m_valid[k] <= 1'b0;
            end else begin
                logic [8:0] r;
                r = ref_add(sizes[k], sats[k], a, b);
                if (in_valid) begin
                    m_sum[k]   <= r[7:0];
                    m_carry[k] <= r[8];
                end
                m_valid[k] <= in_valid;
            end
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: all instances against the model, shortly after the edge.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("model_sum[%0d]", k),   64'(act_sum[k]),   64'(m_sum[k]));
            check($sformatf("model_carry[%0d]", k), 64'(act_carry[k]), 64'(m_carry[k]));
            check($sformatf("model_valid[%0d]", k), 64'(act_valid[k]), 64'(m_valid[k]));
        end
    end

    task automatic drive(logic v, logic [7:0] x, logic [7:0] y);
        @(negedge clk);
        in_valid = v;
        a        = x;
        b        = y;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_clear(string tag);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("%s_sum[%0d]", tag, k),   64'(act_sum[k]),   64'd0);
            check($sformatf("%s_carry[%0d]", tag, k), 64'(act_carry[k]), 64'd0);
            check($sformatf("%s_valid[%0d]", tag, k), 64'(act_valid[k]), 64'd0);
        end
    endtask

    logic [1:0] sw_a   [7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
    logic [1:0] sw_b   [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b11};
    logic [1:0] sw_sum [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b10};
    logic [1:0] sw_sat [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       sw_cy  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       h1_sum [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       h1_cy  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset held with live operands.
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom));
            after_edge();
            check_all_clear("reset_hold");
        end
        drive(1'b0, 8'd0, 8'd0);
        rst = 1'b0;
        after_edge();

        // Directed sweep, back-to-back.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, {6'd0, sw_a[i]}, {6'd0, sw_b[i]});
            after_edge();
            check($sformatf("sweep_sum[%0d]", i),     64'(s2),  64'(sw_sum[i]));
            check($sformatf("sweep_carry[%0d]", i),   64'(c2),  64'(sw_cy[i]));
            check($sformatf("sweep_valid[%0d]", i),   64'(v2),  64'd1);
            check($sformatf("sweep_satsum[%0d]", i),  64'(s2s), 64'(sw_sat[i]));
            check($sformatf("sweep_satcy[%0d]", i),   64'(c2s), 64'(sw_cy[i]));
        end
        drive(1'b0, 8'd0, 8'd0);
        after_edge();
        check("sweep_valid_end", 64'(v2), 64'd0);

        // Hold: one valid then idle cycles with max operands.
        drive(1'b1, 8'h01, 8'h01);
        after_edge();
        check("hold_first_valid", 64'(v2), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'hFF, 8'hFF);
            after_edge();
            check($sformatf("hold_sum[%0d]", i),   64'(s2), 64'h2);
            check($sformatf("hold_carry[%0d]", i), 64'(c2), 64'h0);
            check($sformatf("hold_valid[%0d]", i), 64'(v2), 64'h0);
        end

        // Mid-stream reset, asserted between edges during the 3rd operand.
        drive(1'b1, 8'h01, 8'h01);
        drive(1'b1, 8'h02, 8'h01);
        drive(1'b1, 8'h03, 8'h03);
        #2 rst = 1'b1;
        #1 check_all_clear("async_reset");
        drive(1'b1, 8'h03, 8'h02);
        after_edge();
        check_all_clear("reset_discard");
        drive(1'b0, 8'hFF, 8'hFF);
        rst = 1'b0;
        after_edge();
        check_all_clear("release_idle");
        drive(1'b1, 8'h01, 8'h02);
        after_edge();
        check("post_reset_sum",   64'(s2), 64'h3);
        check("post_reset_valid", 64'(v2), 64'h1);

        // SIZE=1 exhaustive half-adder.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            drive(1'b1, {7'd0, ab[1]}, {7'd0, ab[0]});
            after_edge();
            check($sformatf("half_sum[%0d]", i),   64'(s1), 64'(h1_sum[i]));
            check($sformatf("half_carry[%0d]", i), 64'(c1), 64'(h1_cy[i]));
        end

        // Boundary pins for the 8-bit instances.
        drive(1'b1, 8'hFF, 8'h00);
        after_edge();
        check("b8_max0_sat_sum", 64'(s8s), 64'hFF);
        check("b8_max0_sat_cy",  64'(c8s), 64'h0);
        drive(1'b1, 8'hFF, 8'h01);
        after_edge();
        check("b8_max1_sat_sum",  64'(s8s), 64'hFF);
        check("b8_max1_sat_cy",   64'(c8s), 64'h1);
        check("b8_max1_wrap_sum", 64'(s8),  64'h00);
        drive(1'b1, 8'hFF, 8'hFF);
        after_edge();
        check("b8_maxmax_wrap", 64'({c8, s8}), 64'h1FE);

        // Random traffic, mostly valid, checked by the model every cycle.
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
        end
        drive(1'b0, 8'd0, 8'd0);
        after_edge();
        after_edge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_adder.md
Name: param_adder

Overview:
- Parameterised unsigned adder with a registered output.
- Adds two SIZE-bit operands and produces a SIZE-bit sum that wraps modulo 2^SIZE, plus a carry-out flag.
- Optional saturation mode.
- Used as a generic arithmetic leaf block wherever a width-configurable, one-cycle-latency adder is needed.

Parameters:
- SIZE, default 4: operand and sum width in bits; legal range 1..64.
- SATURATE, default 0: 0 = result wraps modulo 2^SIZE; 1 = result clamps to all-ones on carry.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a and b for the current cycle.
- a  input  SIZE  unsigned operand A.
- b  input  SIZE  unsigned operand B.
- sum  output  SIZE  registered result.
- carry  output  1  registered carry-out of a+b (bit SIZE of the full-width sum).
- out_valid  output  1  sum/carry hold a new result this cycle.

Behaviour:
- Reset: rst high forces sum=0, carry=0, out_valid=0 immediately, without waiting for clk. Outputs stay there while rst is high.
- Full-width sum: full = a + b, computed at SIZE+1 bits with zero-extended operands.
- Latency: exactly 1 cycle. On a rising clk edge with rst low and in_valid=1, the outputs update as follows:
  - carry <= full[SIZE].
  - sum <= full[SIZE-1:0] when SATURATE=0.
  - sum <= all-ones when SATURATE=1 and carry=1; otherwise sum <= full[SIZE-1:0].
  - out_valid <= 1.
- Idle cycle: on a rising edge with in_valid=0, sum and carry hold their previous values and out_valid <= 0.
- Throughput: one result per cycle. Back-to-back in_valid cycles produce back-to-back out_valid cycles with no bubbles.
- No backpressure. Downstream must accept a result in the cycle out_valid is high.
- Wrap-around, SATURATE=0: max+max yields sum = all-ones minus 1 (e.g. SIZE=2: 3+3 -> sum 2'b10) with carry=1.
- Boundary, SATURATE=1: max+0 gives sum=max, carry=0. max+1 gives sum=max, carry=1.
- Reset mid-stream: asserting rst while in_valid is high discards the in-flight operation. The first post-reset result appears one cycle after the first valid input that follows rst deassertion.
- Reset release: deassertion is sampled at clk. No output changes until the next rising edge with in_valid=1.
- SIZE=1 must work: the block degenerates to a registered half-adder.
- No X propagation from operands when in_valid=0. Outputs depend only on registered state.

Test Plan:
- Reset check: hold rst=1 with random a/b and in_valid=1 for several cycles -> sum=0, carry=0, out_valid=0. Pulse rst asynchronously between edges -> outputs clear without a clock edge.
- SIZE=2, SATURATE=0 sweep: apply (a,b) = (00,00), (01,00), (01,01), (10,01), (11,00), (11,01), (11,11), one per cycle with in_valid=1.
  - Sums one cycle later: 00, 01, 10, 11, 11, 00, 10.
  - Carries: 0, 0, 0, 0, 0, 1, 1.
  - out_valid high for exactly 7 cycles.
- SIZE=2, SATURATE=1 with (11,01) and (11,11) -> sum=11, carry=1 for both; (10,01) -> sum=11, carry=0.
- Hold check: valid (01,01), then in_valid=0 with a=11, b=11 for 3 cycles -> sum stays 10, carry 0, out_valid drops to 0 after one cycle.
- Mid-stream reset: stream 4 valid operands, assert rst during the 3rd -> outputs clear immediately.
  - After release, the next valid (01,10) gives sum=11 one cycle later.
  - No stale result appears.
- Width scaling: SIZE=8, SATURATE=0, 200 random operand pairs -> each {carry,sum} equals a+b one cycle later. SIZE=1 exhaustive check of all 4 combinations.
